// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, debounces whole-scan
// results, and reports each accepted press as a code plus a one-cycle strobe.
// Decimal keys are shifted into a 4-digit BCD register; '*' clears it.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,  // clk_50 cycles per row dwell, >= 8
  parameter int DEBOUNCE_SCANS = 4       // matching scans to accept, 2..15
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] bcd_value
);

  localparam int             TW       = $clog2(SCAN_DIV);
  localparam logic [TW-1:0]  TICK_MAX = TW'(SCAN_DIV - 1);
  localparam logic [3:0]     DEB      = 4'(DEBOUNCE_SCANS);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  // Hit counts saturate at "many" because two or more low bits all mean NONE.
  localparam logic [1:0] HITS_NONE = 2'd0;
  localparam logic [1:0] HITS_ONE  = 2'd1;
  localparam logic [1:0] HITS_MANY = 2'd2;

  logic [3:0]    col_meta, col_sync;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [1:0]    row_idx;
  logic [2:0]    row_low_n;
  logic [1:0]    row_col;
  logic [1:0]    acc_hits, tot_hits;
  logic [3:0]    acc_key, tot_key;
  logic          scan_done, scan_single, scan_none;
  logic [1:0]    state;
  logic [3:0]    cnt, cnt_next, cand, cand_code;

  // Map a key index (row*4 + col) to its reported code.
  function automatic logic [3:0] key_map(input logic [3:0] idx);
    case (idx)
      4'd0:  key_map = 4'h1;
      4'd1:  key_map = 4'h2;
      4'd2:  key_map = 4'h3;
      4'd3:  key_map = 4'hA;
      4'd4:  key_map = 4'h4;
      4'd5:  key_map = 4'h5;
      4'd6:  key_map = 4'h6;
      4'd7:  key_map = 4'hB;
      4'd8:  key_map = 4'h7;
      4'd9:  key_map = 4'h8;
      4'd10: key_map = 4'h9;
      4'd11: key_map = 4'hC;
      4'd12: key_map = 4'hE;
      4'd13: key_map = 4'h0;
      4'd14: key_map = 4'hF;
      default: key_map = 4'hD;
    endcase
  endfunction

  // Two-flop synchronizer for the asynchronous column returns; idles high.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, regardless of the order statements appear in.
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      col_meta <= 4'b1111;
      col_sync <= 4'b1111;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
    end
  end

  // Row dwell timer: wraps every SCAN_DIV cycles, ticking on the last one.
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick = (tick_cnt == TICK_MAX);

  // Row driver: rotate the single low bit after each row has been sampled.
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      row_idx <= 2'd0;
      row_out <= 4'b1110;
    end else if (tick) begin
      row_idx <= row_idx + 2'd1;
      row_out <= {row_out[2:0], row_out[3]};
    end
  end

  // Count low columns on the current row and remember the (last) low one.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    row_low_n = 3'd0;
    row_col   = 2'd0;
    for (int c = 0; c < 4; c++) begin
      if (!col_sync[c]) begin
        row_low_n = row_low_n + 3'd1;
        row_col   = 2'(c);
      end
    end
  end

  // Merge this row into the running scan tally.
  always_comb begin
    tot_hits = acc_hits;
    tot_key  = acc_key;
    if (row_low_n >= 3'd2) begin
      tot_hits = HITS_MANY;
    end else if (row_low_n == 3'd1) begin
      if (acc_hits == HITS_NONE) begin
        tot_hits = HITS_ONE;
        tot_key  = {row_idx, row_col};
      end else begin
        tot_hits = HITS_MANY;
      end
    end
  end

  assign scan_done   = tick && (row_idx == 2'd3);
  assign scan_single = scan_done && (tot_hits == HITS_ONE);
  assign scan_none   = scan_done && (tot_hits == HITS_NONE);

  // Scan tally: accumulate rows 0..2, restart once row 3 has produced a result.
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      acc_hits <= HITS_NONE;
      acc_key  <= 4'd0;
    end else if (scan_done) begin
      acc_hits <= HITS_NONE;
      acc_key  <= 4'd0;
    end else if (tick) begin
      acc_hits <= tot_hits;
      acc_key  <= tot_key;
    end
  end

  assign cnt_next  = cnt + 4'd1;
  assign cand_code = key_map(cand);

  // Debounce FSM plus the registered outputs it drives on accept/release.
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cand      <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      bcd_value <= 16'h0000;
    end else begin
      key_valid <= 1'b0;
      if (scan_done) begin
        case (state)
          IDLE: begin
            if (scan_single) begin
              cand  <= tot_key;
              cnt   <= 4'd1;
              state <= PRESS_WAIT;
            end
          end
          PRESS_WAIT: begin
            if (scan_single && (tot_key == cand)) begin
              cnt <= cnt_next;
              if (cnt_next == DEB) begin
                state     <= HELD;
                key_code  <= cand_code;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                if (cand_code <= 4'd9)
                  bcd_value <= {bcd_value[11:0], cand_code};
                else if (cand_code == 4'hE)
                  bcd_value <= 16'h0000;
              end
            end else begin
              cnt   <= 4'd0;
              state <= IDLE;
            end
          end
          HELD: begin
            if (scan_none) begin
              cnt   <= 4'd1;
              state <= RELEASE_WAIT;
            end
          end
          default: begin  // RELEASE_WAIT
            if (scan_none) begin
              cnt <= cnt_next;
              if (cnt_next == DEB) begin
                key_held <= 1'b0;
                state    <= IDLE;
              end
            end else begin
              state <= HELD;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with SCAN_DIV=8 and
// DEBOUNCE_SCANS=3. A keypad model drives the columns from the row drive;
// expected accepts are queued when a press starts and popped on key_valid.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 8;
  localparam int DEB      = 3;

  typedef struct packed {
    logic [3:0]  code;
    logic [15:0] bcd;
  } exp_t;

  logic        clk_50 = 1'b0;
  logic        reset  = 1'b0;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] bcd_value;

  logic [15:0] keys = 16'h0000;   // bit r*4+c set = key (r,c) pressed
  exp_t        exp_q[$];
  logic [15:0] model_bcd = 16'h0000;
  int          checks = 0;
  int          failures = 0;
  int          valid_count = 0;
  int          pushed = 0;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk_50   (clk_50),
    .reset    (reset),
    .col_in   (col_in),
    .row_out  (row_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held),
    .bcd_value(bcd_value)
  );

  always #10 clk_50 = ~clk_50;

  // Keypad model: a pressed key shorts its column to its row while driven low.
  always_comb begin
    col_in = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference key map, laid out as the physical keypad.
  function automatic logic [3:0] ref_code(input int idx);
    logic [3:0] tbl [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                             4'h4, 4'h5, 4'h6, 4'hB,
                             4'h7, 4'h8, 4'h9, 4'hC,
                             4'hE, 4'h0, 4'hF, 4'hD};
    return tbl[idx];
  endfunction

  // Queue the accept a press of key idx should produce and advance the BCD model.
  task automatic expect_accept(input int idx);
    logic [3:0] code;
    code = ref_code(idx);
    if (code <= 4'd9)       model_bcd = {model_bcd[11:0], code};
    else if (code == 4'hE)  model_bcd = 16'h0000;
    exp_q.push_back('{code: code, bcd: model_bcd});
    pushed++;
  endtask

  // Scoreboard monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk_50) begin
    if (reset && key_valid) begin
      valid_count++;
      check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_key_code", 32'(key_code), 32'(e.code));
        check("sb_bcd_value", 32'(bcd_value), 32'(e.bcd));
        check("sb_key_held", 32'(key_held), 32'd1);
      end
    end
  end

  // Advance n scan boundaries (row 3 -> row 0 wrap), each bounded in cycles.
  task automatic wait_scans(input int n);
    for (int i = 0; i < n; i++) begin
      logic [3:0] prev;
      bit         seen;
      seen = 1'b0;
      prev = row_out;
      for (int k = 0; k < 4 * SCAN_DIV + 8 && !seen; k++) begin
        @(negedge clk_50);
        if (prev == 4'b0111 && row_out == 4'b1110) seen = 1'b1;
        prev = row_out;
      end
      check("scan_boundary_seen", 32'(seen), 32'd1);
    end
  endtask

  // Full press/release of one key, checking acceptance and release latency.
  task automatic press_release(input int idx);
    keys = 16'h0000;
    keys[idx] = 1'b1;
    expect_accept(idx);
    wait_scans(DEB - 1);
    check("held_before_accept", 32'(key_held), 32'd0);
    wait_scans(1);
    check("held_at_accept", 32'(key_held), 32'd1);
    check("code_at_accept", 32'(key_code), 32'(ref_code(idx)));
    wait_scans(2);
    keys = 16'h0000;
    wait_scans(DEB - 1);
    check("held_before_release", 32'(key_held), 32'd1);
    wait_scans(1);
    check("held_after_release", 32'(key_held), 32'd0);
  endtask

  initial begin
    int vc;
    // Reset state
    repeat (5) @(negedge clk_50);
    check("rst_row_out", 32'(row_out), 32'h0000_000E);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_key_held", 32'(key_held), 32'd0);
    check("rst_key_code", 32'(key_code), 32'd0);
    check("rst_bcd_value", 32'(bcd_value), 32'd0);
    reset = 1'b1;
    repeat (SCAN_DIV - 1) @(negedge clk_50);
    check("row_dwell_row0", 32'(row_out), 32'h0000_000E);
    @(negedge clk_50);
    check("row_rotate_row1", 32'(row_out), 32'h0000_000D);
    repeat (SCAN_DIV) @(negedge clk_50);
    check("row_rotate_row2", 32'(row_out), 32'h0000_000B);
    wait_scans(1);

    // Single press of key (1,1) -> code 5
    vc = valid_count;
    keys[5] = 1'b1;
    expect_accept(5);
    wait_scans(DEB);
    check("single_held", 32'(key_held), 32'd1);
    wait_scans(3);
    check("single_one_pulse", 32'(valid_count - vc), 32'd1);
    check("single_code", 32'(key_code), 32'd5);
    check("single_bcd", 32'(bcd_value), 32'h0005);
    keys = 16'h0000;
    wait_scans(DEB - 1);
    check("single_held_rwait", 32'(key_held), 32'd1);
    wait_scans(1);
    check("single_released", 32'(key_held), 32'd0);

    // Digit entry 1,2,3,4,5 then clear and '#'
    press_release(0);
    press_release(1);
    press_release(2);
    press_release(4);
    press_release(5);
    check("digits_bcd", 32'(bcd_value), 32'h2345);
    press_release(12);
    check("star_code", 32'(key_code), 32'hE);
    check("star_bcd", 32'(bcd_value), 32'h0000);
    press_release(10);
    check("nine_bcd", 32'(bcd_value), 32'h0009);
    press_release(14);
    check("hash_code", 32'(key_code), 32'hF);
    check("hash_bcd", 32'(bcd_value), 32'h0009);

    // Bounce: 2 scans on, 1 off, 2 on, released -> nothing accepted
    vc = valid_count;
    keys = 16'h0001;
    wait_scans(2);
    keys = 16'h0000;
    wait_scans(1);
    keys = 16'h0001;
    wait_scans(2);
    check("bounce_held", 32'(key_held), 32'd0);
    keys = 16'h0000;
    wait_scans(3);
    check("bounce_no_pulse", 32'(valid_count - vc), 32'd0);
    check("bounce_held_end", 32'(key_held), 32'd0);

    // Two keys (3 and 9) together -> NONE every scan
    keys = 16'h0000;
    keys[2] = 1'b1;
    keys[10] = 1'b1;
    wait_scans(5);
    check("multi_no_pulse", 32'(valid_count - vc), 32'd0);
    check("multi_held", 32'(key_held), 32'd0);
    keys = 16'h0000;
    wait_scans(1);

    // Hold 7 until accepted, then add 8 -> no second pulse
    keys[8] = 1'b1;
    expect_accept(8);
    wait_scans(DEB);
    check("seven_held", 32'(key_held), 32'd1);
    keys[9] = 1'b1;
    wait_scans(4);
    check("seven_one_pulse", 32'(valid_count - vc), 32'd1);
    check("seven_code_kept", 32'(key_code), 32'd7);
    check("seven_bcd", 32'(bcd_value), 32'h0097);
    check("seven_still_held", 32'(key_held), 32'd1);
    keys = 16'h0000;
    wait_scans(DEB);
    check("seven_released", 32'(key_held), 32'd0);

    // Reset in PRESS_WAIT with cnt=2, key kept pressed through reset
    vc = valid_count;
    keys[6] = 1'b1;
    wait_scans(2);
    repeat (5) @(negedge clk_50);
    reset = 1'b0;
    model_bcd = 16'h0000;
    @(negedge clk_50);
    check("mid_rst_row_out", 32'(row_out), 32'h0000_000E);
    check("mid_rst_key_code", 32'(key_code), 32'd0);
    check("mid_rst_bcd", 32'(bcd_value), 32'd0);
    check("mid_rst_held", 32'(key_held), 32'd0);
    repeat (3) @(negedge clk_50);
    reset = 1'b1;
    check("mid_rst_no_pulse", 32'(valid_count - vc), 32'd0);
    expect_accept(6);
    wait_scans(DEB - 1);
    check("post_rst_held_early", 32'(key_held), 32'd0);
    wait_scans(1);
    check("post_rst_held", 32'(key_held), 32'd1);
    check("post_rst_code", 32'(key_code), 32'd6);
    check("post_rst_bcd", 32'(bcd_value), 32'h0006);
    keys = 16'h0000;
    wait_scans(DEB + 1);

    check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    check("total_pulses", 32'(valid_count), 32'(pushed));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
